// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    // Memory-access sequencing states.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default abort limit, in cycles spent waiting in REQ.
    localparam int DEF_TIMEOUT = 255;

    // Register $0 is hard-wired to zero, so it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    input  logic [4:0] rd_addr,
    input  logic       ex_mem_read,
    output logic       load_use
);

    // A load writing a non-zero register that the ID instruction reads.
    always_comb begin
        load_use = ex_mem_read && (rd_addr != REG_ZERO) &&
                   ((rd_addr == rs_addr) || (rd_addr == rt_addr));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: memory handshake FSM, hazard/branch priority and stall counter.
// Handshake: DMem_Req_o is held high from the cycle after the access is
// seen until the cycle DMem_Ack_i is sampled high (or the wait is aborted);
// an ack is honoured only while DMem_Req_o is high, and RData_Latch_o marks
// the single cycle in which both are high.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RsAddr_i,
    input  logic [4:0]       IF_ID_RtAddr_i,
    input  logic [4:0]       ID_EX_RdAddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             Branch_Taken_i,
    input  logic             MEM_MemRead_i,
    input  logic             MEM_MemWrite_i,
    input  logic             DMem_Ack_i,
    output logic             DMem_Req_o,
    output logic             RData_Latch_o,
    output logic             PC_Stall_o,
    output logic             IF_ID_Stall_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic             EX_MEM_Stall_o,
    output logic             MEM_WB_Bubble_o,
    output logic             Mem_Err_o,
    output logic [CNT_W-1:0] Stall_Cnt_o,
    output state_t           state_o
);

    state_t            state, state_next;
    logic              req;
    logic              mem_err;
    logic              timed_out;
    logic [TO_W-1:0]   to_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    logic              mem_acc;
    logic              mem_stall;
    logic              load_use;
    logic              lu_active;
    logic              timeout_hit;
    logic              pc_stall;

    assign mem_acc = MEM_MemRead_i | MEM_MemWrite_i;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .rs_addr     (IF_ID_RsAddr_i),
        .rt_addr     (IF_ID_RtAddr_i),
        .rd_addr     (ID_EX_RdAddr_i),
        .ex_mem_read (ID_EX_MemRead_i),
        .load_use    (load_use)
    );

    // Next-state: wait in REQ for ack or abort after TIMEOUT cycles; DONE lasts one cycle.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            RUN: begin
                if (mem_acc) state_next = REQ;
            end
            REQ: begin
                if (DMem_Ack_i) begin
                    state_next = DONE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Control outputs by priority: mem stall, then load-use, then branch; all zero in reset.
    always_comb begin
        mem_stall       = mem_acc && (state != DONE);
        lu_active       = load_use && !mem_stall;
        pc_stall        = mem_stall || lu_active;
        PC_Stall_o      = rst_i && pc_stall;
        IF_ID_Stall_o   = rst_i && pc_stall;
        ID_EX_Flush_o   = rst_i && lu_active;
        IF_ID_Flush_o   = rst_i && Branch_Taken_i && !mem_stall && !load_use;
        EX_MEM_Stall_o  = rst_i && mem_stall;
        MEM_WB_Bubble_o = rst_i && (mem_stall || ((state == DONE) && timed_out));
    end

    // State, request, timeout tracking and saturating stall counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= RUN;
            req       <= 1'b0;
            mem_err   <= 1'b0;
            timed_out <= 1'b0;
            to_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            req   <= (state_next == REQ);
            if ((state != REQ) && (state_next == REQ)) begin
                to_cnt <= '0;
            end else if (state == REQ) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout_hit) begin
                mem_err   <= 1'b1;
                timed_out <= 1'b1;
            end else if (state == DONE) begin
                timed_out <= 1'b0;
            end
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign DMem_Req_o    = req;
    assign RData_Latch_o = req & DMem_Ack_i;
    assign Mem_Err_o     = mem_err;
    assign Stall_Cnt_o   = stall_cnt;
    assign state_o       = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for hazard/branch, hand sequences for memory.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  rs, rt, rd;
    logic        ex_mr, br, mr, mw, ack;
    logic        req, latch, pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic        exmem_stall, bubble, mem_err;
    logic [31:0] stall_cnt;
    state_t      st;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       ex_mr, br, mr, mw, ack;
        logic [7:0] exp;   // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, bubble, req, latch}
    } vec_t;

    vec_t tbl[8];

    pipe_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .IF_ID_RsAddr_i  (rs),
        .IF_ID_RtAddr_i  (rt),
        .ID_EX_RdAddr_i  (rd),
        .ID_EX_MemRead_i (ex_mr),
        .Branch_Taken_i  (br),
        .MEM_MemRead_i   (mr),
        .MEM_MemWrite_i  (mw),
        .DMem_Ack_i      (ack),
        .DMem_Req_o      (req),
        .RData_Latch_o   (latch),
        .PC_Stall_o      (pc_stall),
        .IF_ID_Stall_o   (ifid_stall),
        .IF_ID_Flush_o   (ifid_flush),
        .ID_EX_Flush_o   (idex_flush),
        .EX_MEM_Stall_o  (exmem_stall),
        .MEM_WB_Bubble_o (bubble),
        .Mem_Err_o       (mem_err),
        .Stall_Cnt_o     (stall_cnt),
        .state_o         (st)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [4:0] a_rs, input logic [4:0] a_rt,
                                input logic [4:0] a_rd, input logic a_ex_mr,
                                input logic a_br, input logic a_mr, input logic a_mw,
                                input logic a_ack, input logic [7:0] a_exp);
        vec_t v;
        v.rs = a_rs; v.rt = a_rt; v.rd = a_rd; v.ex_mr = a_ex_mr;
        v.br = a_br; v.mr = a_mr; v.mw = a_mw; v.ack = a_ack; v.exp = a_exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then compare outputs.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk_i);
        rs = v.rs; rt = v.rt; rd = v.rd; ex_mr = v.ex_mr;
        br = v.br; mr = v.mr; mw = v.mw; ack = v.ack;
        #1;
        check({name, " outs"}, {24'd0, pc_stall, ifid_stall, ifid_flush, idex_flush,
                                exmem_stall, bubble, req, latch}, {24'd0, v.exp});
        check({name, " stall_cnt"}, stall_cnt, exp_cnt);
        if (v.exp[7]) exp_cnt++;
    endtask

    task automatic idle_inputs();
        rs = 5'd0; rt = 5'd0; rd = 5'd0; ex_mr = 1'b0;
        br = 1'b0; mr = 1'b0; mw = 1'b0; ack = 1'b0;
    endtask

    initial begin
        // Hazard / branch table, all taken with no memory access (state RUN).
        tbl[0] = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000);
        tbl[1] = mk(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1101_0000);
        tbl[2] = mk(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1101_0000);
        tbl[3] = mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000);
        tbl[4] = mk(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000);
        tbl[5] = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0010_0000);
        tbl[6] = mk(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1101_0000);
        tbl[7] = mk(5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0010_0000);

        // Reset with hazard, branch and memory inputs active: everything forced low.
        rst_i = 1'b0;
        rs = 5'd5; rt = 5'd5; rd = 5'd5; ex_mr = 1'b1;
        br = 1'b1; mr = 1'b1; mw = 1'b0; ack = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("reset outs", {24'd0, pc_stall, ifid_stall, ifid_flush, idex_flush,
                             exmem_stall, bubble, req, latch}, 32'd0);
        check("reset stall_cnt", stall_cnt, 32'd0);
        check("reset mem_err", {31'd0, mem_err}, 32'd0);
        check("reset state", {30'd0, st}, {30'd0, RUN});
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Load in MEM, ack on the third REQ cycle.
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1100_1100), "ld c0");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1100_1110), "ld c1");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1100_1110), "ld c2");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'b1100_1111), "ld c3");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000), "ld done");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000), "ld after");

        // Back-to-back stores: early ack ignored, ack with Req rising accepted.
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1100), "st0 c0");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1111), "st0 c1");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0000), "st0 done");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b1100_1100), "st1 c0");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1111), "st1 c1");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0000), "st1 done");
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000), "st after");
        check("mem_err before timeout", {31'd0, mem_err}, 32'd0);

        // Timeout after exactly 4 REQ cycles, then a dropped instruction in DONE.
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1100_1100), "to c0");
        for (int i = 1; i <= 4; i++) begin
            apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1100_1110),
                  $sformatf("to c%0d", i));
        end
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0100), "to done");
        check("mem_err set", {31'd0, mem_err}, 32'd1);
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000), "to after");
        check("mem_err sticky", {31'd0, mem_err}, 32'd1);
        check("state after timeout", {30'd0, st}, {30'd0, RUN});

        // Memory stall masks load-use and branch; then reset while waiting in REQ.
        apply(mk(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1100_1100), "mask c0");
        apply(mk(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1100_1110), "mask c1");
        #1;
        rst_i = 1'b0;
        #1;
        check("midreq reset outs", {24'd0, pc_stall, ifid_stall, ifid_flush, idex_flush,
                                    exmem_stall, bubble, req, latch}, 32'd0);
        check("midreq reset stall_cnt", stall_cnt, 32'd0);
        check("midreq reset mem_err", {31'd0, mem_err}, 32'd0);
        check("midreq reset state", {30'd0, st}, {30'd0, RUN});
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
        exp_cnt = 0;
        apply(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000), "post reset");
        check("post reset state", {30'd0, st}, {30'd0, RUN});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the 5-stage core. It generates the stall, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and applies taken-branch flushes. It runs a req/ack handshake with a variable-latency data memory, freezing the pipeline until the access in MEM completes or times out.

## Interface
- TIMEOUT, 255: max cycles in REQ before abort; legal 1..2^TO_W-1.
- TO_W, 8: timeout counter width.
- CNT_W, 32: stall counter width.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- IF_ID_RsAddr_i  in  5  rs of instruction in ID
- IF_ID_RtAddr_i  in  5  rt of instruction in ID
- ID_EX_RdAddr_i  in  5  destination of instruction in EX
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- Branch_Taken_i  in  1  branch resolved taken in ID
- MEM_MemRead_i  in  1  instruction in MEM is a load
- MEM_MemWrite_i  in  1  instruction in MEM is a store
- DMem_Ack_i  in  1  data memory completes the access; read data valid this cycle
- DMem_Req_o  out  1  data memory request, registered
- RData_Latch_o  out  1  capture memory read data (= DMem_Req_o & DMem_Ack_i)
- PC_Stall_o  out  1  hold PC
- IF_ID_Stall_o  out  1  hold IF/ID
- IF_ID_Flush_o  out  1  zero IF/ID
- ID_EX_Flush_o  out  1  load ID/EX with zero controls
- EX_MEM_Stall_o  out  1  hold EX/MEM
- MEM_WB_Bubble_o  out  1  load MEM/WB with RegWrite=0, MemToReg=0
- Mem_Err_o  out  1  sticky timeout flag
- Stall_Cnt_o  out  CNT_W  saturating count of stalled cycles

## Operation
- mem_acc = MEM_MemRead_i | MEM_MemWrite_i.
- FSM states:
  - RUN: if mem_acc, go to REQ.
  - REQ: DMem_Req_o=1. On DMem_Ack_i, go to DONE. When to_cnt reaches TIMEOUT without ack, set Mem_Err_o and timed_out_q, then go to DONE.
  - DONE: one cycle; go to RUN unconditionally.
- mem_stall = mem_acc & (state != DONE).
  - Asserts PC_Stall_o, IF_ID_Stall_o, EX_MEM_Stall_o and MEM_WB_Bubble_o.
  - ID/EX is held, not flushed: ID_EX_Flush_o=0 and the ID/EX enable is tied to ~EX_MEM_Stall_o in the datapath.
- In DONE, the pipeline advances and MEM/WB loads the latched data.
  - If timed_out_q is set, MEM_WB_Bubble_o=1 and the instruction is dropped.
  - timed_out_q clears on leaving DONE.
- load_use = ID_EX_MemRead_i & (ID_EX_RdAddr_i != 0) & (RdAddr == RsAddr | RdAddr == RtAddr).
  - Applies only when ~mem_stall.
  - Asserts PC_Stall_o, IF_ID_Stall_o and ID_EX_Flush_o.
- Branch flush: IF_ID_Flush_o = Branch_Taken_i & ~mem_stall & ~load_use.
- Priority, highest first: reset, mem_stall, load_use, branch. Lower-priority actions are suppressed entirely in that cycle.
- Stall_Cnt_o increments on any cycle with PC_Stall_o=1 and saturates at all-ones.
- to_cnt clears on entry to REQ.

## Timing
- Reset (async):
  - state=RUN; DMem_Req_o=0; Mem_Err_o=0; timed_out_q=0; to_cnt=0; Stall_Cnt_o=0.
  - All stall, flush and bubble outputs are forced 0 while rst_i=0.
- Reset mid-REQ: DMem_Req_o drops immediately and the request is abandoned.
- Memory access latency:
  - Cycle 0 (RUN, mem_acc): stall asserted, Req still 0.
  - Cycle 1: Req=1.
  - Ack in cycle k≥1 leads to DONE in cycle k+1.
  - Minimum cost: 2 stalled cycles plus 1 DONE cycle.
- Ack in the same cycle Req rises is legal. Ack while Req=0 is ignored.
- Timeout: abort after exactly TIMEOUT cycles in REQ.
- Back-to-back memory ops: DONE, then RUN sees the next mem_acc, then REQ. No cycle is lost beyond RUN→REQ.
- load_use and branch outputs are combinational, same cycle as their inputs.

## Structure
- pipe_ctrl_pkg:
  - state enum (RUN, REQ, DONE).
  - default TIMEOUT.
  - REG_ZERO constant (5'd0).
- Sub-module hazard_detect: combinational load_use compare, instantiated once.
- pipe_ctrl holds the FSM, counters and output priority logic.

## Test plan
- Load in MEM, ack on 3rd REQ cycle:
  - Req high for 3 cycles.
  - RData_Latch_o pulses once.
  - Stall for 4 cycles, then DONE advances.
  - Stall_Cnt_o=4.
- Load-use hazard (EX lw writes $5, ID uses $5 as rt): 1 cycle of PC/IF_ID stall plus ID_EX flush. With RdAddr=0, no stall.
- Branch_Taken_i together with load_use: only the load-use response; the flush appears the following cycle.
- TIMEOUT=4, no ack: Req high for 4 cycles, Mem_Err_o set, DONE with MEM_WB_Bubble_o=1, return to RUN.
- rst_i low during REQ: DMem_Req_o=0 immediately. After release: state RUN, Stall_Cnt_o=0, Mem_Err_o=0.
